// File: rtl/chan_frame_collector_pkg.sv
// Shared definitions for the channel frame collector.
//   - state_e     : collector FSM states
//   - DATA_W_DEF  : default sample width
//   - FRAME_CNT_W : width of the published-frame counter
package chan_frame_collector_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,  // waiting for channel 0 to align on a frame
    ST_COLLECT = 2'd1,  // accepting channels in order
    ST_HOLD    = 2'd2   // frame done, consumer still holds the previous one
  } state_e;

endpackage

// File: rtl/chan_frame_bank.sv
// Double-buffered frame storage: two banks of CHANNELS x DATA_W registers.
// Ports:
//   clk, reset        : clock, async active-low reset (read register only)
//   i_wr_sel          : bank being written; the other bank is the read bank
//   i_wr_en/addr/data : write port into the write bank
//   i_rd_addr         : read address into the read bank
//   o_rd_data         : registered read data, 0 for addresses >= CHANNELS
module chan_frame_bank
  import chan_frame_collector_pkg::*;
#(
  parameter int CHANNELS     = 32,
  parameter int CHANNELS_PW2 = 7,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wr_sel,
  input  logic                    i_wr_en,
  input  logic [CHANNELS_PW2-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic [CHANNELS_PW2-1:0] i_rd_addr,
  output logic [DATA_W-1:0]       o_rd_data
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHANNELS_PW2:0] NUM_CH = (CHANNELS_PW2+1)'(CHANNELS);

  logic [DATA_W-1:0] r_mem [2][CHANNELS];
  logic [DATA_W-1:0] r_rd_data;
  logic              w_rd_sel;
  logic              w_wr_ok;
  logic              w_rd_ok;

  assign w_rd_sel = ~i_wr_sel;
  // Range checks use the full address so a non-power-of-two CHANNELS never
  // aliases onto a real slot.
  assign w_wr_ok  = i_wr_en && ({1'b0, i_wr_addr} < NUM_CH);
  assign w_rd_ok  = {1'b0, i_rd_addr} < NUM_CH;

  // NOTE: storage has no reset; a frame is only published once every slot
  // has been written, so stale contents are never visible as valid data.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      // NOTE: non-blocking assignment for all clocked state.
      r_mem[i_wr_sel][i_wr_addr[IDX_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (w_rd_ok) begin
      r_rd_data <= r_mem[w_rd_sel][i_rd_addr[IDX_W-1:0]];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/chan_frame_collector.sv
// Sink of the per-channel sample stream. Collects one sample per channel
// into a double-buffered frame and publishes it through a registered
// random-access read port, backpressuring the stream while the consumer
// still holds the previous frame.
// Ports:
//   clk, reset           : clock, async active-low reset
//   chan_in_sample/num   : incoming sample and its channel index
//   chan_in_valid/read   : stream handshake, transfer = valid & read
//   frame_valid          : read bank holds a complete frame
//   frame_read           : one-cycle pulse, consumer done with the frame
//   rd_addr/rd_data      : read port, 1-cycle latency, 0 when out of range
//   frame_count          : number of frames published (wraps)
//   seq_error            : one-cycle pulse on an out-of-order channel
module chan_frame_collector
  import chan_frame_collector_pkg::*;
#(
  parameter int CHANNELS     = 32,
  parameter int CHANNELS_PW2 = 7,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       chan_in_sample,
  input  logic [CHANNELS_PW2-1:0] chan_in_num,
  input  logic                    chan_in_valid,
  output logic                    chan_in_read,
  output logic                    frame_valid,
  input  logic                    frame_read,
  input  logic [CHANNELS_PW2-1:0] rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic [FRAME_CNT_W-1:0]  frame_count,
  output logic                    seq_error
);

  localparam logic [CHANNELS_PW2-1:0] LAST_CH = CHANNELS_PW2'(CHANNELS - 1);

  state_e                   r_state, w_state_nxt;
  logic                     r_wr_sel, w_wr_sel_nxt;
  logic [CHANNELS_PW2-1:0]  r_expected, w_expected_nxt;
  logic                     r_chan_in_read;
  logic                     r_frame_valid, w_frame_valid_nxt;
  logic [FRAME_CNT_W-1:0]   r_frame_count, w_frame_count_nxt;
  logic                     r_seq_error, w_seq_error_nxt;
  logic                     w_xfer;
  logic                     w_in_seq;
  logic                     w_wr_en;
  logic                     w_complete;
  logic                     w_swap;

  assign w_xfer   = chan_in_valid & r_chan_in_read;
  // In SYNC only channel 0 is in sequence; in COLLECT the expected index is.
  assign w_in_seq = (r_state == ST_SYNC) ? (chan_in_num == '0)
                                         : (chan_in_num == r_expected);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_nxt       = r_state;
    w_wr_sel_nxt      = r_wr_sel;
    w_expected_nxt    = r_expected;
    w_frame_valid_nxt = r_frame_valid;
    w_frame_count_nxt = r_frame_count;
    w_seq_error_nxt   = 1'b0;
    w_wr_en           = 1'b0;
    w_complete        = 1'b0;
    w_swap            = 1'b0;

    if (w_xfer && r_state != ST_HOLD) begin
      if (w_in_seq || chan_in_num == '0) begin
        // In-order sample, or an out-of-order channel 0 restarting the frame.
        w_wr_en         = 1'b1;
        w_expected_nxt  = chan_in_num + CHANNELS_PW2'(1);
        w_state_nxt     = ST_COLLECT;
        w_seq_error_nxt = !w_in_seq;
        w_complete      = (chan_in_num == LAST_CH);
      end else if (r_state == ST_COLLECT) begin
        w_seq_error_nxt = 1'b1;
        w_state_nxt     = ST_SYNC;
      end
    end

    if (w_complete) begin
      w_expected_nxt = '0;
      if (!r_frame_valid || frame_read) begin
        w_swap = 1'b1;
      end else begin
        w_state_nxt = ST_HOLD;
      end
    end

    if (r_state == ST_HOLD && frame_read) begin
      w_swap         = 1'b1;
      w_state_nxt    = ST_COLLECT;
      w_expected_nxt = '0;
    end

    if (w_swap) begin
      w_wr_sel_nxt      = ~r_wr_sel;
      w_frame_valid_nxt = 1'b1;
      w_frame_count_nxt = r_frame_count + FRAME_CNT_W'(1);
    end else if (frame_read) begin
      w_frame_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_SYNC;
      r_wr_sel       <= 1'b0;
      r_expected     <= '0;
      r_chan_in_read <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_frame_count  <= '0;
      r_seq_error    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_sel       <= w_wr_sel_nxt;
      r_expected     <= w_expected_nxt;
      // Registered ready: low for exactly the cycles spent in HOLD.
      r_chan_in_read <= (w_state_nxt != ST_HOLD);
      r_frame_valid  <= w_frame_valid_nxt;
      r_frame_count  <= w_frame_count_nxt;
      r_seq_error    <= w_seq_error_nxt;
    end
  end

  chan_frame_bank #(
    .CHANNELS     (CHANNELS),
    .CHANNELS_PW2 (CHANNELS_PW2),
    .DATA_W       (DATA_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_sel  (r_wr_sel),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (chan_in_num),
    .i_wr_data (chan_in_sample),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign chan_in_read = r_chan_in_read;
  assign frame_valid  = r_frame_valid;
  assign frame_count  = r_frame_count;
  assign seq_error    = r_seq_error;

endmodule

// File: tb/tb_chan_frame_collector.sv
// Directed bench: a 4-channel instance driven from a cycle-by-cycle vector
// table, plus hand-written sequences for async reset and a 1-channel instance.
module tb_chan_frame_collector;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        v4, fr4, rd4, fv4, err4;
  logic [6:0]  num4, addr4;
  logic [15:0] smp4, data4, cnt4;

  // 1-channel instance
  logic        v1, fr1, rd1, fv1, err1;
  logic [6:0]  num1, addr1;
  logic [15:0] smp1, data1, cnt1;

  chan_frame_collector #(.CHANNELS(4), .CHANNELS_PW2(7), .DATA_W(16)) dut4 (
    .clk(clk), .reset(reset),
    .chan_in_sample(smp4), .chan_in_num(num4), .chan_in_valid(v4),
    .chan_in_read(rd4), .frame_valid(fv4), .frame_read(fr4),
    .rd_addr(addr4), .rd_data(data4), .frame_count(cnt4), .seq_error(err4)
  );

  chan_frame_collector #(.CHANNELS(1), .CHANNELS_PW2(7), .DATA_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .chan_in_sample(smp1), .chan_in_num(num1), .chan_in_valid(v1),
    .chan_in_read(rd1), .frame_valid(fv1), .frame_read(fr1),
    .rd_addr(addr1), .rd_data(data1), .frame_count(cnt1), .seq_error(err1)
  );

  typedef struct {
    logic        v;
    logic [6:0]  num;
    logic [15:0] smp;
    logic        fr;
    logic [6:0]  addr;
    logic        e_rd;
    logic        e_fv;
    logic [15:0] e_cnt;
    logic        e_err;
    logic        chk_d;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input logic v, input logic [6:0] num, input logic [15:0] smp,
                     input logic fr, input logic [6:0] addr,
                     input logic e_rd, input logic e_fv, input logic [15:0] e_cnt,
                     input logic e_err, input logic chk_d, input logic [15:0] e_data);
    vec_t t;
    t.v = v; t.num = num; t.smp = smp; t.fr = fr; t.addr = addr;
    t.e_rd = e_rd; t.e_fv = e_fv; t.e_cnt = e_cnt; t.e_err = e_err;
    t.chk_d = chk_d; t.e_data = e_data;
    vecs.push_back(t);
  endtask

  task automatic drive4(input logic v, input logic [6:0] num, input logic [15:0] smp,
                        input logic fr, input logic [6:0] addr);
    @(negedge clk);
    v4 = v; num4 = num; smp4 = smp; fr4 = fr; addr4 = addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    v4 = 0; num4 = 0; smp4 = 0; fr4 = 0; addr4 = 0;
    v1 = 0; num1 = 0; smp1 = 0; fr1 = 0; addr1 = 0;

    //   v num smp      fr addr   rd fv cnt err chk data
    // normal frame
    row(0, 0, 16'h0000, 0, 0,   1, 0, 0, 0, 0, 16'h0000);
    row(1, 0, 16'h0011, 0, 0,   1, 0, 0, 0, 0, 16'h0000);
    row(1, 1, 16'h0022, 0, 0,   1, 0, 0, 0, 0, 16'h0000);
    row(1, 2, 16'h0033, 0, 0,   1, 0, 0, 0, 0, 16'h0000);
    row(1, 3, 16'h0044, 0, 0,   1, 1, 1, 0, 0, 16'h0000);
    row(0, 0, 16'h0000, 0, 0,   1, 1, 1, 0, 1, 16'h0011);
    row(0, 0, 16'h0000, 0, 1,   1, 1, 1, 0, 1, 16'h0022);
    row(0, 0, 16'h0000, 0, 2,   1, 1, 1, 0, 1, 16'h0033);
    row(0, 0, 16'h0000, 0, 3,   1, 1, 1, 0, 1, 16'h0044);
    row(0, 0, 16'h0000, 0, 5,   1, 1, 1, 0, 1, 16'h0000);
    // backpressure: second frame completes while the first is held
    row(1, 0, 16'h0101, 0, 0,   1, 1, 1, 0, 1, 16'h0011);
    row(1, 1, 16'h0202, 0, 0,   1, 1, 1, 0, 1, 16'h0011);
    row(1, 2, 16'h0303, 0, 0,   1, 1, 1, 0, 1, 16'h0011);
    row(1, 3, 16'h0404, 0, 0,   0, 1, 1, 0, 1, 16'h0011);
    row(1, 0, 16'h0999, 0, 0,   0, 1, 1, 0, 1, 16'h0011);
    row(0, 0, 16'h0000, 0, 0,   0, 1, 1, 0, 1, 16'h0011);
    row(0, 0, 16'h0000, 1, 0,   1, 1, 2, 0, 0, 16'h0000);
    row(0, 0, 16'h0000, 0, 0,   1, 1, 2, 0, 1, 16'h0101);
    row(0, 0, 16'h0000, 0, 3,   1, 1, 2, 0, 1, 16'h0404);
    // release without swap, then a frame_read with nothing held
    row(0, 0, 16'h0000, 1, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(0, 0, 16'h0000, 1, 0,   1, 0, 2, 0, 1, 16'h0101);
    // sequence error 0,1,3 then SYNC drops num 2 silently, then 0..3
    row(1, 0, 16'h0A0A, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 1, 16'h0B0B, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 3, 16'h0C0C, 0, 0,   1, 0, 2, 1, 1, 16'h0101);
    row(0, 0, 16'h0000, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 2, 16'h7777, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 0, 16'h1111, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 1, 16'h2222, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 2, 16'h3333, 0, 0,   1, 0, 2, 0, 1, 16'h0101);
    row(1, 3, 16'h4444, 0, 0,   1, 1, 3, 0, 1, 16'h0101);
    row(0, 0, 16'h0000, 0, 2,   1, 1, 3, 0, 1, 16'h3333);
    row(0, 0, 16'h0000, 0, 3,   1, 1, 3, 0, 1, 16'h4444);
    row(0, 0, 16'h0000, 0, 0,   1, 1, 3, 0, 1, 16'h1111);
    row(0, 0, 16'h0000, 1, 0,   1, 0, 3, 0, 1, 16'h1111);
    // restart on zero: 0,1,0,1,2,3
    row(1, 0, 16'h5001, 0, 0,   1, 0, 3, 0, 1, 16'h1111);
    row(1, 1, 16'h5002, 0, 0,   1, 0, 3, 0, 1, 16'h1111);
    row(1, 0, 16'h6001, 0, 0,   1, 0, 3, 1, 1, 16'h1111);
    row(1, 1, 16'h6002, 0, 0,   1, 0, 3, 0, 1, 16'h1111);
    row(1, 2, 16'h6003, 0, 0,   1, 0, 3, 0, 1, 16'h1111);
    row(1, 3, 16'h6004, 0, 0,   1, 1, 4, 0, 1, 16'h1111);
    row(0, 0, 16'h0000, 0, 0,   1, 1, 4, 0, 1, 16'h6001);
    row(0, 0, 16'h0000, 0, 1,   1, 1, 4, 0, 1, 16'h6002);
    row(0, 0, 16'h0000, 0, 3,   1, 1, 4, 0, 1, 16'h6004);
    // frame completes in the same cycle as frame_read: immediate swap
    row(1, 0, 16'h7001, 0, 0,   1, 1, 4, 0, 1, 16'h6001);
    row(1, 1, 16'h7002, 0, 0,   1, 1, 4, 0, 1, 16'h6001);
    row(1, 2, 16'h7003, 0, 0,   1, 1, 4, 0, 1, 16'h6001);
    row(1, 3, 16'h7004, 1, 0,   1, 1, 5, 0, 0, 16'h0000);
    row(0, 0, 16'h0000, 0, 1,   1, 1, 5, 0, 1, 16'h7002);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset rd4", 32'(rd4), 32'(1'b0));
    check("reset fv4", 32'(fv4), 32'(1'b0));
    check("reset cnt4", 32'(cnt4), 32'(16'h0));
    check("reset err4", 32'(err4), 32'(1'b0));
    check("reset data4", 32'(data4), 32'(16'h0));
    check("reset rd1", 32'(rd1), 32'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i].v, vecs[i].num, vecs[i].smp, vecs[i].fr, vecs[i].addr);
      check($sformatf("row%0d read", i), 32'(rd4), 32'(vecs[i].e_rd));
      check($sformatf("row%0d frame_valid", i), 32'(fv4), 32'(vecs[i].e_fv));
      check($sformatf("row%0d frame_count", i), 32'(cnt4), 32'(vecs[i].e_cnt));
      check($sformatf("row%0d seq_error", i), 32'(err4), 32'(vecs[i].e_err));
      if (vecs[i].chk_d)
        check($sformatf("row%0d rd_data", i), 32'(data4), 32'(vecs[i].e_data));
    end

    // async reset mid-frame after nums 0,1
    drive4(1, 0, 16'hDEAD, 0, 0);
    drive4(1, 1, 16'hBEEF, 0, 0);
    #1;
    v4 = 0;
    reset = 1'b0;
    #1;
    check("async rd4", 32'(rd4), 32'(1'b0));
    check("async fv4", 32'(fv4), 32'(1'b0));
    check("async cnt4", 32'(cnt4), 32'(16'h0));
    check("async data4", 32'(data4), 32'(16'h0));
    check("async err4", 32'(err4), 32'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    drive4(0, 0, 16'h0000, 0, 0);
    check("post-reset read", 32'(rd4), 32'(1'b1));
    for (int n = 0; n < 4; n++)
      drive4(1, 7'(n), 16'h8001 + 16'(n), 0, 0);
    check("post-reset fv", 32'(fv4), 32'(1'b1));
    check("post-reset cnt", 32'(cnt4), 32'(16'h1));
    drive4(0, 0, 16'h0000, 0, 2);
    check("post-reset data", 32'(data4), 32'(16'h8003));

    // single-channel instance: every num 0 transfer is a frame
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v1 = 1; num1 = 0; smp1 = 16'hA000 + 16'(k); fr1 = (k > 1); addr1 = 0;
      @(posedge clk);
      #1;
      check($sformatf("ch1 cnt k%0d", k), 32'(cnt1), 32'(k));
      check($sformatf("ch1 fv k%0d", k), 32'(fv1), 32'(1'b1));
      check($sformatf("ch1 err k%0d", k), 32'(err1), 32'(1'b0));
      if (k > 1)
        check($sformatf("ch1 data k%0d", k), 32'(data1), 32'(16'hA000 + 16'(k - 1)));
    end
    @(negedge clk);
    v1 = 0; fr1 = 1; addr1 = 0;
    @(posedge clk);
    #1;
    check("ch1 last data", 32'(data1), 32'(16'hA005));
    check("ch1 final cnt", 32'(cnt1), 32'(16'h5));
    check("ch1 released", 32'(fv1), 32'(1'b0));
    @(negedge clk);
    fr1 = 0; addr1 = 1;
    @(posedge clk);
    #1;
    check("ch1 oob data", 32'(data1), 32'(16'h0));
    check("ch1 no err", 32'(err1), 32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
